// File: rtl/axi_wr_protocol_checker.sv
// Passive AXI3 write-path protocol checker: snoops AW/W/B, tracks outstanding bursts,
// and reports stability, ordering, WLAST, overflow and timeout violations.
module axi_wr_protocol_checker #(
    parameter int unsigned ID_W     = 4,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned LEN_W    = 4,
    parameter int unsigned MAX_OUTS = 4,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic                           aclk,
    input  logic                           arst,
    input  logic                           clr_err,
    input  logic [ID_W-1:0]                awid,
    input  logic [ADDR_W-1:0]              awaddr,
    input  logic [LEN_W-1:0]               awlen,
    input  logic                           awvalid,
    input  logic                           awready,
    input  logic [ID_W-1:0]                wid,
    input  logic [DATA_W-1:0]              wdata,
    input  logic [DATA_W/8-1:0]            wstrob,
    input  logic                           wlast,
    input  logic                           wvalid,
    input  logic                           wready,
    input  logic [ID_W-1:0]                bid,
    input  logic [1:0]                     bresp,
    input  logic                           bvalid,
    input  logic                           bready,
    output logic [9:0]                     err_vec,
    output logic                           err_pulse,
    output logic                           first_err_vld,
    output logic [3:0]                     first_err_code,
    output logic [$clog2(MAX_OUTS+1)-1:0]  outs_cnt
);
    localparam int unsigned CNT_W   = $clog2(MAX_OUTS + 1);
    localparam int unsigned PTR_W   = (MAX_OUTS > 1) ? $clog2(MAX_OUTS) : 1;
    localparam int unsigned TO_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int unsigned AW_PL_W = ID_W + ADDR_W + LEN_W;
    localparam int unsigned W_PL_W  = ID_W + DATA_W + DATA_W/8 + 1;
    localparam int unsigned B_PL_W  = ID_W + 2;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUTS - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    logic [AW_PL_W-1:0] aw_pl, aw_pl_q;
    logic [W_PL_W-1:0]  w_pl,  w_pl_q;
    logic [B_PL_W-1:0]  b_pl,  b_pl_q;
    logic               aw_v_q, aw_r_q, w_v_q, w_r_q, b_v_q, b_r_q;

    logic [ID_W-1:0]  awq_id  [MAX_OUTS];
    logic [LEN_W-1:0] awq_len [MAX_OUTS];
    logic [ID_W-1:0]  bq_id   [MAX_OUTS];
    logic [PTR_W-1:0] awq_rd, awq_wr, bq_rd, bq_wr;
    logic [CNT_W-1:0] awq_cnt, bq_cnt;
    logic [LEN_W-1:0] w_beat;
    logic [TO_W-1:0]  to_cnt [3];

    logic aw_hs, w_hs, b_hs, awq_empty, bq_empty;
    logic aw_room, aw_push, w_act, w_done, beat_last, b_pop;
    logic [ID_W-1:0]  head_id;
    logic [LEN_W-1:0] head_len;
    logic [2:0] tv, tr, to_hit;
    logic [9:0] det;
    logic [3:0] det_code;

    assign aw_pl = {awid, awaddr, awlen};
    assign w_pl  = {wid, wdata, wstrob, wlast};
    assign b_pl  = {bid, bresp};
    assign aw_hs = awvalid & awready;
    assign w_hs  = wvalid & wready;
    assign b_hs  = bvalid & bready;
    assign tv    = {bvalid, wvalid, awvalid};
    assign tr    = {bready, wready, awready};

    assign awq_empty = (awq_cnt == '0);
    assign bq_empty  = (bq_cnt == '0);
    // Same-cycle AW bypass: an empty queue exposes the incoming AW as the head
    assign head_id   = awq_empty ? awid  : awq_id[awq_rd];
    assign head_len  = awq_empty ? awlen : awq_len[awq_rd];
    assign b_pop     = b_hs & ~bq_empty;
    assign aw_room   = (outs_cnt != CNT_W'(MAX_OUTS)) | b_pop;
    assign aw_push   = aw_hs & aw_room;
    assign w_act     = w_hs & (~awq_empty | aw_push);
    assign beat_last = (w_beat == head_len);
    assign w_done    = w_act & (wlast | beat_last);

    always_comb begin
        to_hit = '0;
        for (int i = 0; i < 3; i++)
            to_hit[i] = (TIMEOUT != 0) && tv[i] && !tr[i] && (to_cnt[i] == TO_W'(TIMEOUT - 1));
    end

    always_comb begin
        det    = '0;
        det[0] = aw_v_q & ~aw_r_q & (~awvalid | (aw_pl != aw_pl_q));
        det[1] = w_v_q  & ~w_r_q  & (~wvalid  | (w_pl  != w_pl_q));
        det[2] = b_v_q  & ~b_r_q  & (~bvalid  | (b_pl  != b_pl_q));
        det[3] = w_act & (wlast != beat_last);
        det[4] = w_act & (wid != head_id);
        det[5] = w_hs & awq_empty & ~aw_hs;
        det[6] = b_hs & bq_empty;
        det[7] = b_pop & (bid != bq_id[bq_rd]);
        det[8] = aw_hs & (outs_cnt == CNT_W'(MAX_OUTS)) & ~b_hs;
        det[9] = |to_hit;
    end

    // Lowest set index wins
    always_comb begin
        det_code = '0;
        for (int i = 9; i >= 0; i--)
            if (det[i]) det_code = 4'(i);
    end

    always_ff @(posedge aclk) begin
        if (aw_push) begin
            awq_id[awq_wr]  <= awid;
            awq_len[awq_wr] <= awlen;
        end
        if (w_done) bq_id[bq_wr] <= head_id;
    end

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            aw_pl_q <= '0; w_pl_q <= '0; b_pl_q <= '0;
            aw_v_q  <= 1'b0; aw_r_q <= 1'b0;
            w_v_q   <= 1'b0; w_r_q  <= 1'b0;
            b_v_q   <= 1'b0; b_r_q  <= 1'b0;
            awq_rd  <= '0; awq_wr <= '0; awq_cnt <= '0;
            bq_rd   <= '0; bq_wr  <= '0; bq_cnt  <= '0;
            w_beat  <= '0;
            outs_cnt <= '0;
            for (int i = 0; i < 3; i++) to_cnt[i] <= '0;
            err_vec <= '0; err_pulse <= 1'b0;
            first_err_vld <= 1'b0; first_err_code <= '0;
        end else begin
            aw_pl_q <= aw_pl; w_pl_q <= w_pl; b_pl_q <= b_pl;
            aw_v_q  <= awvalid; aw_r_q <= awready;
            w_v_q   <= wvalid;  w_r_q  <= wready;
            b_v_q   <= bvalid;  b_r_q  <= bready;

            if (aw_push) awq_wr <= ptr_inc(awq_wr);
            if (w_done)  awq_rd <= ptr_inc(awq_rd);
            awq_cnt <= awq_cnt + CNT_W'(aw_push) - CNT_W'(w_done);

            if (w_done) bq_wr <= ptr_inc(bq_wr);
            if (b_pop)  bq_rd <= ptr_inc(bq_rd);
            bq_cnt <= bq_cnt + CNT_W'(w_done) - CNT_W'(b_pop);

            if (w_done)     w_beat <= '0;
            else if (w_act) w_beat <= w_beat + LEN_W'(1);

            outs_cnt <= outs_cnt + CNT_W'(aw_push) - CNT_W'(b_pop);

            for (int i = 0; i < 3; i++) begin
                if (!tv[i] || tr[i])                  to_cnt[i] <= '0;
                else if (to_cnt[i] != TO_W'(TIMEOUT)) to_cnt[i] <= to_cnt[i] + TO_W'(1);
            end

            err_vec   <= clr_err ? det : (err_vec | det);
            err_pulse <= |det;
            // A fresh error on the clearing cycle is recorded as the new first error
            if ((|det) && (!first_err_vld || clr_err)) begin
                first_err_vld  <= 1'b1;
                first_err_code <= det_code;
            end else if (clr_err) begin
                first_err_vld  <= 1'b0;
                first_err_code <= '0;
            end
        end
    end
endmodule

// File: doc/axi_wr_protocol_checker.md
# axi_wr_protocol_checker

- Synthesizable, parametrised AXI3 write-path protocol checker.
- Passively snoops the AW, W and B channels between master and slave, and tracks outstanding bursts in internal queues.
- Checks valid/payload stability, WLAST placement against AWLEN, WID/BID ordering, outstanding-depth overflow and handshake timeouts.
- Reports violations as sticky error bits, a one-cycle pulse and a first-error code. It replaces simulation-only assertion checks on the environment interface and is usable in emulation and on silicon debug buses.

## Interface
Parameters:
- ID_W, 4: width of awid/wid/bid.
- ADDR_W, 32: awaddr width.
- DATA_W, 32: wdata width; the strobe width is DATA_W/8.
- LEN_W, 4: awlen width (AXI3 is 4).
- MAX_OUTS, 4: maximum outstanding write transactions (AW accepted, B not yet accepted); must be ≥1.
- TIMEOUT, 16: cycles a valid may wait for its ready before an error; 0 disables the check.

Ports:
- aclk, in, 1: single clock; all sampling on its rising edge.
- arst, in, 1: asynchronous, active-high reset.
- clr_err, in, 1: synchronous clear of err_vec, first_err_vld and first_err_code only; queues are untouched.
- awid/awaddr/awlen/awvalid/awready, in, ID_W/ADDR_W/LEN_W/1/1: snooped write-address channel.
- wid/wdata/wstrob/wlast/wvalid/wready, in, ID_W/DATA_W/DATA_W/8/1/1/1: snooped write-data channel.
- bid/bresp/bvalid/bready, in, ID_W/2/1/1: snooped write-response channel.
- err_vec, out, 10: sticky error flags (bit map below).
- err_pulse, out, 1: high for one cycle when any error bit is newly detected.
- first_err_vld, out, 1: set by the first error after reset or clr_err.
- first_err_code, out, 4: lowest-index error bit detected in that first cycle.
- outs_cnt, out, $clog2(MAX_OUTS+1): current count of outstanding transactions.

## Operation
Error bit map:
- 0 AW_STABLE: AW payload changed, or awvalid dropped, while waiting for awready.
- 1 W_STABLE: same rule for the W channel.
- 2 B_STABLE: same rule for the B channel.
- 3 WLAST: wlast missing on the final beat, or asserted on an earlier beat.
- 4 WID: wid does not equal the head AW entry id.
- 5 W_EARLY: W handshake with no AW queued and no AW handshake in the same cycle.
- 6 B_UNEXP: B handshake with the B queue empty.
- 7 BID: bid does not equal the B queue head.
- 8 AW_OVF: AW handshake while outs_cnt==MAX_OUTS and no B handshake in the same cycle.
- 9 TIMEOUT: any channel's valid held high with ready low for TIMEOUT consecutive cycles.

Stability: the block registers valid, ready and the payload of each channel. If the previous edge had valid=1 and ready=0, the current edge requires valid=1 and an identical payload.

AW queue (depth MAX_OUTS, {id,len}):
- Pushed on AW handshake; a bypass path lets a same-cycle W beat use the incoming AW fields.
- Overflowing pushes are dropped and AW_OVF is set.

W beat counter (LEN_W bits):
- On each W handshake, compare to head len.
- Beat counts 0..len; wlast must be 1 exactly when beat==len.
- The burst completes on a handshake with wlast=1 OR beat==len. On completion: pop the AW entry, push its id into the B queue, clear the counter.
- A W_EARLY beat does not advance any state.

B queue (depth MAX_OUTS, id):
- Popped on B handshake after the BID compare.
- A same-cycle burst completion is not visible to that B handshake, so B_UNEXP is raised.

outs_cnt: +1 on an accepted (non-dropped) AW, −1 on a non-B_UNEXP B handshake; both in the same cycle leaves it unchanged.

Timeout counters: one per channel. Each resets when valid=0 or on handshake and saturates at TIMEOUT; reaching TIMEOUT sets bit 9 once.

## Timing
- Reset (async assert, sync release): err_vec=0, err_pulse=0, first_err_vld=0, first_err_code=0, outs_cnt=0, all queues empty, all counters 0.
- Detection latency: violation sampled at edge N → err_vec/err_pulse/first_err updated at edge N+1 (registered outputs, no combinational path from inputs).
- Multiple errors in one cycle: all bits set; first_err_code takes the lowest index.
- first_err is frozen until clr_err or reset.
- clr_err in the same cycle as a new error: the new error wins and is recorded.
- arst mid-burst: all tracking is discarded. Traffic after release that continues an old burst is flagged W_EARLY/B_UNEXP by design.

## Test plan
- AW id=3 len=3 accepted, then 4 W beats wid=3 with wlast on beat 3, then B bid=3 → err_vec=0, outs_cnt 0→1→0.
- awvalid=1, awready=0 for 2 cycles with awaddr changing 0x100→0x104 → bit0 set one cycle later; err_pulse=1 for one cycle; first_err_code=0.
- len=1 burst with wlast on beat 0 → bit3 set; the burst closes; a following B with the correct id → no further errors.
- 4 AWs with no B, then a 5th AW (MAX_OUTS=4) → bit8, outs_cnt stays 4. A 5th AW in the same cycle as a B handshake → no error, outs_cnt stays 4.
- AW id=1 then id=2, both bursts completed, then B bid=2 → bit7 set; B with an empty queue → bit6.
- wvalid=1 with wready=0 for 16 cycles (TIMEOUT=16) → bit9 set at cycle 17. clr_err → err_vec=0, first_err_vld=0.
